muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq.sv | 176 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Sequential unsigned multiply/divide unit: 16-cycle radix-2
// shift-add multiply and restoring divide, registered outputs.
module muldiv_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             divzero
);

  localparam int W = WIDTH;

  localparam logic [1:0] OP_MULL = 2'd0;
  localparam logic [1:0] OP_MULH = 2'd1;
  localparam logic [1:0] OP_DIV  = 2'd2;
  localparam logic [1:0] OP_MOD  = 2'd3;

  localparam logic [4:0] LAST_STEP = 5'(W - 1);

  // One-hot so busy/done come straight off state flops.
  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_RUN  = 3'b010,
    S_DONE = 3'b100
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [4:0]     r_cnt;
  logic [1:0]     r_op;
  logic [W-1:0]   r_opnd;
  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_rem;
  logic [W-1:0]   r_result;
  logic           r_ovf;
  logic           r_divzero;

  logic           w_accept;
  logic           w_dz;
  logic           w_last;

  logic [W:0]     w_mul_sum;
  logic [2*W-1:0] w_mul_acc;
  logic [W:0]     w_rem_sh;
  logic           w_ge;
  logic [W-1:0]   w_sub;
  logic [W-1:0]   w_div_rem;
  logic [W-1:0]   w_div_q;
  logic [2*W-1:0] w_step_acc;
  logic [W-1:0]   w_res;
  logic           w_ovf;

  assign w_accept = start & (r_state[0] | r_state[2]);
  assign w_dz     = op[1] & (b == '0);
  assign w_last   = (r_cnt == LAST_STEP);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: divide by zero bypasses RUN entirely.
  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      r_state[0]: begin
        if (start) begin
          w_next = w_dz ? S_DONE : S_RUN;
        end
      end
      r_state[1]: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      r_state[2]: begin
        if (start) begin
          w_next = w_dz ? S_DONE : S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // One radix-2 step of each algorithm plus final result select.
  always_comb begin
    // Multiply: {hi, lo}; lo holds the multiplier and
    // drains out the bottom as the product shifts in.
    w_mul_sum = {1'b0, r_acc[2*W-1:W]}
              + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_mul_acc = {w_mul_sum, r_acc[W-1:1]};

    // Divide: lo of acc is the dividend/quotient shifter.
    // The shifted partial remainder needs W+1 bits; after
    // the restore step it is below the divisor again.
    w_rem_sh  = {r_rem, r_acc[W-1]};
    w_ge      = (w_rem_sh >= {1'b0, r_opnd});
    w_sub     = w_rem_sh[W-1:0] - r_opnd;
    w_div_rem = w_ge ? w_sub : w_rem_sh[W-1:0];
    w_div_q   = {r_acc[W-2:0], w_ge};

    w_step_acc = r_op[1] ? {r_acc[2*W-1:W], w_div_q}
                         : w_mul_acc;

    w_res = '0;
    w_ovf = 1'b0;
    unique case (r_op)
      OP_MULL: begin
        w_res = w_mul_acc[W-1:0];
        w_ovf = |w_mul_acc[2*W-1:W];
      end
      OP_MULH: w_res = w_mul_acc[2*W-1:W];
      OP_DIV:  w_res = w_div_q;
      OP_MOD:  w_res = w_div_rem;
      default: w_res = '0;
    endcase
  end

  // Datapath: latch on accept, step in RUN, publish on DONE entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_op      <= OP_MULL;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
      r_divzero <= 1'b0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_op   <= op;
      r_opnd <= op[1] ? b : a;
      r_acc  <= {{W{1'b0}}, (op[1] ? a : b)};
      r_rem  <= '0;
      if (w_dz) begin
        r_result  <= (op == OP_MOD) ? a : '1;
        r_ovf     <= 1'b0;
        r_divzero <= 1'b1;
      end
    end else if (r_state[1]) begin
      r_cnt <= r_cnt + 5'd1;
      r_acc <= w_step_acc;
      if (r_op[1]) begin
        r_rem <= w_div_rem;
      end
      if (w_last) begin
        r_result  <= w_res;
        r_ovf     <= w_ovf;
        r_divzero <= 1'b0;
      end
    end
  end

  assign busy    = r_state[1];
  assign done    = r_state[2];
  assign result  = r_result;
  assign ovf     = r_ovf;
  assign divzero = r_divzero;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized self-checking bench for muldiv_seq against a
// plain-arithmetic reference model.
module tb_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        ovf;
  logic        divzero;

  int nchk;
  int nfail;
  logic [15:0] prev_res;

  muldiv_seq #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .ovf     (ovf),
    .divzero (divzero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: what the unit must report for one op.
  task automatic model(input logic [1:0] op_i,
                       input logic [15:0] a_i,
                       input logic [15:0] b_i,
                       output logic [15:0] er,
                       output logic eo,
                       output logic ez);
    longint unsigned prod;
    prod = longint'(a_i) * longint'(b_i);
    er = 16'h0;
    eo = 1'b0;
    ez = (op_i >= 2) && (b_i == 0);
    case (op_i)
      2'd0: begin
        er = 16'(prod % 65536);
        eo = (prod >= 65536);
      end
      2'd1: er = 16'(prod / 65536);
      2'd2: er = (b_i == 0) ? 16'hFFFF : a_i / b_i;
      default: er = (b_i == 0) ? a_i : a_i % b_i;
    endcase
  endtask

  // Wait gap cycles (result must hold), issue op, optionally
  // fire a stray start at RUN cycle inj, check timing/values.
  // Returns at the negedge of the done cycle.
  task automatic run(input logic [1:0] op_i,
                     input logic [15:0] a_i,
                     input logic [15:0] b_i,
                     input int gap,
                     input int inj);
    logic [15:0] er;
    logic eo, ez;
    int lat, nbusy, both;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      check("hold_res", 32'(result), 32'(prev_res));
    end
    model(op_i, a_i, b_i, er, eo, ez);
    start = 1'b1;
    op = op_i;
    a = a_i;
    b = b_i;
    @(posedge clk);
    lat = 0;
    nbusy = 0;
    both = 0;
    for (int n = 1; n <= 24 && lat == 0; n++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (busy && done) both++;
      if (done) lat = n;
      if (lat == 0 && n != 16 && n < 20) begin
        check("res_held_run", 32'(result), 32'(prev_res));
      end
      start = (n == inj);
      if (n == inj) begin
        op = 2'($urandom);
        a = 16'($urandom);
        b = 16'($urandom);
      end
    end
    start = 1'b0;
    check("latency", 32'(lat), ez ? 32'd1 : 32'd17);
    check("busy_cycles", 32'(nbusy), ez ? 32'd0 : 32'd16);
    check("busy_and_done", 32'(both), 32'd0);
    check("result", 32'(result), 32'(er));
    check("ovf", 32'(ovf), 32'(eo));
    check("divzero", 32'(divzero), 32'(ez));
    prev_res = er;
  endtask

  initial begin
    int ndone;
    nchk = 0;
    nfail = 0;
    prev_res = 16'h0;
    start = 1'b0;
    op = 2'd0;
    a = 16'h0;
    b = 16'h0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_divzero", 32'(divzero), 32'd0);
    rst = 1'b1;

    run(2'd0, 16'd300, 16'd200, 1, 0);
    check("s_mull_300x200", 32'(result), 32'h0000EA60);
    run(2'd0, 16'd1000, 16'd1000, 2, 0);
    check("s_mull_1000sq", 32'(result), 32'h00004240);
    check("s_mull_ovf", 32'(ovf), 32'd1);
    run(2'd1, 16'd1000, 16'd1000, 1, 0);
    check("s_mulh_1000sq", 32'(result), 32'h0000000F);
    run(2'd2, 16'd50000, 16'd7, 1, 0);
    check("s_div", 32'(result), 32'h00001BE6);
    run(2'd3, 16'd50000, 16'd7, 1, 0);
    check("s_mod", 32'(result), 32'h00000006);
    run(2'd2, 16'd5, 16'd0, 1, 0);
    check("s_div0", 32'(result), 32'h0000FFFF);
    run(2'd3, 16'd5, 16'd0, 1, 0);
    check("s_mod0", 32'(result), 32'h00000005);
    run(2'd0, 16'd0, 16'd1234, 1, 0);
    run(2'd0, 16'hFFFF, 16'hFFFF, 0, 0);
    run(2'd1, 16'hFFFF, 16'hFFFF, 0, 0);
    run(2'd0, 16'd3, 16'd4, 2, 5);
    check("s_ignored", 32'(result), 32'h0000000C);
    run(2'd0, 16'd9, 16'd9, 0, 0);
    check("s_b2b", 32'(result), 32'h00000051);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    start = 1'b1;
    op = 2'd0;
    a = 16'd1234;
    b = 16'd567;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    prev_res = 16'h0;
    run(2'd1, 16'd40000, 16'd3, 0, 0);

    for (int i = 0; i < 60; i++) begin
      logic [1:0]  rop;
      logic [15:0] ra;
      logic [15:0] rb;
      int rinj;
      rop = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(1, 15));
      rinj = ($urandom_range(0, 4) == 0) ? $urandom_range(2, 15) : 0;
      run(rop, ra, rb, $urandom_range(0, 2), rinj);
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
